ctrl_pipe: RTL and testbench

Pipeline control carrier and hazard unit: receives the per-instruction control bundle produced by the ID-stage decoder and carries it through ID/EX, EX/MEM and MEM/WB registers. It detects load-use and RAW hazards, generates the IF/ID stall and flush requests, and drives the EX-stage operand forwarding selects. It sits between the decoder and the datapath stage registers of the 5-stage MIPS pipeline.

---
 rtl/ctrl_pipe_pkg.sv | 28 ++
 rtl/ctrl_pipe_if.sv | 43 ++++
 rtl/ctrl_pipe_hazard_fwd.sv | 61 ++++++
 rtl/ctrl_pipe.sv | 106 ++++++++++
 tb/tb_ctrl_pipe.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the pipeline control carrier: bundle layout,
// forwarding select codes and the reset value of the control bundle.
package ctrl_pipe_pkg;

  localparam int CTRL_W = 15;
  localparam int RA_W   = 5;

  localparam int REGWR_BIT = 14;
  localparam int MEMRD_BIT = 13;
  localparam int ASEL_LSB  = 11;
  localparam int BSEL_BIT  = 10;
  localparam int ALUOP_LSB = 5;
  localparam int BE_LSB    = 3;
  localparam int DMWR_BIT  = 2;
  localparam int WSEL_LSB  = 0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] BE_SW = 2'b10;

  // Empty stage after reset still carries a word byte-enable.
  localparam logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(BE_SW) << BE_LSB;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decoder-side inputs and stage-register outputs of ctrl_pipe bundled as one port.
interface ctrl_pipe_if #(
  parameter int CTRL_W = ctrl_pipe_pkg::CTRL_W,
  parameter int RA_W   = ctrl_pipe_pkg::RA_W
);
  logic              hold;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [RA_W-1:0]   id_rs;
  logic [RA_W-1:0]   id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [RA_W-1:0]   id_wdst;
  logic              id_redirect;

  logic              ex_valid;
  logic              mem_valid;
  logic              wb_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [RA_W-1:0]   ex_rs;
  logic [RA_W-1:0]   ex_rt;
  logic [RA_W-1:0]   ex_wdst;
  logic [RA_W-1:0]   mem_wdst;
  logic [RA_W-1:0]   wb_wdst;
  logic              stall;
  logic              flush_ifid;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output hold, id_valid, id_ctrl, id_rs, id_rt, id_use_rs, id_use_rt, id_wdst, id_redirect,
    input  ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_rs, ex_rt, ex_wdst, mem_wdst, wb_wdst, stall, flush_ifid, fwd_a, fwd_b
  );

  modport slave (
    input  hold, id_valid, id_ctrl, id_rs, id_rt, id_use_rs, id_use_rt, id_wdst, id_redirect,
    output ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_rs, ex_rt, ex_wdst, mem_wdst, wb_wdst, stall, flush_ifid, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe_hazard_fwd.sv
// Combinational hazard detection and EX operand forwarding selects.
// CTRL_PIPE_FWD_EN enables forwarding; otherwise any EX/MEM dependency stalls.
module hazard_fwd #(
  parameter int RA_W = 5
) (
  input  logic            hold,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_redirect,
  input  logic            ex_wr,
  input  logic            ex_memrd,
  input  logic [RA_W-1:0] ex_wdst,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            mem_wr,
  input  logic            mem_memrd,
  input  logic [RA_W-1:0] mem_wdst,
  input  logic            wb_wr,
  input  logic [RA_W-1:0] wb_wdst,
  output logic            stall,
  output logic            flush_ifid,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);
  import ctrl_pipe_pkg::*;

  logic ex_hit;
  logic mem_hit;

  // *_wr already folds in stage valid, regwr and a non-zero destination.
  assign ex_hit  = ex_wr  && ((id_use_rs && ex_wdst  == id_rs) || (id_use_rt && ex_wdst  == id_rt));
  assign mem_hit = mem_wr && ((id_use_rs && mem_wdst == id_rs) || (id_use_rt && mem_wdst == id_rt));

`ifdef CTRL_PIPE_FWD_EN
  function automatic fwd_sel_e fwd_sel(input logic [RA_W-1:0] src);
    if (mem_wr && !mem_memrd && mem_wdst == src) return FWD_MEM;
    if (wb_wr && wb_wdst == src)                 return FWD_WB;
    return FWD_REG;
  endfunction

  assign stall = id_valid && !hold && ex_hit && ex_memrd;
  assign fwd_a = fwd_sel(ex_rs);
  assign fwd_b = fwd_sel(ex_rt);

  logic unused_nofwd;
  assign unused_nofwd = mem_hit;
`else
  assign stall = id_valid && !hold && (ex_hit || mem_hit);
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;

  logic unused_fwd;
  assign unused_fwd = ^{ex_memrd, mem_memrd, wb_wr, wb_wdst, ex_rs, ex_rt};
`endif

  assign flush_ifid = id_redirect && id_valid && !stall && !hold;

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control-bundle registers with hazard/forward unit.
// Define CTRL_PIPE_FWD_EN to build with operand forwarding.
module ctrl_pipe #(
  parameter int CTRL_W = ctrl_pipe_pkg::CTRL_W,
  parameter int RA_W   = ctrl_pipe_pkg::RA_W
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);
  import ctrl_pipe_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [RA_W-1:0]   wdst;
  } stage_t;

  localparam stage_t STAGE_RST = '{valid: 1'b0, ctrl: CTRL_RST, wdst: '0};
  localparam stage_t STAGE_BUB = '{valid: 1'b0, ctrl: '0, wdst: '0};

  stage_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [RA_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic            stall;
  logic            ex_wr, mem_wr, wb_wr;

  assign ex_wr  = ex_q.valid  && ex_q.ctrl[REGWR_BIT]  && (ex_q.wdst  != '0);
  assign mem_wr = mem_q.valid && mem_q.ctrl[REGWR_BIT] && (mem_q.wdst != '0);
  assign wb_wr  = wb_q.valid  && wb_q.ctrl[REGWR_BIT]  && (wb_q.wdst  != '0);

  hazard_fwd #(.RA_W(RA_W)) u_hazard (
    .hold        (bus.hold),
    .id_valid    (bus.id_valid),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_use_rs   (bus.id_use_rs),
    .id_use_rt   (bus.id_use_rt),
    .id_redirect (bus.id_redirect),
    .ex_wr       (ex_wr),
    .ex_memrd    (ex_q.ctrl[MEMRD_BIT]),
    .ex_wdst     (ex_q.wdst),
    .ex_rs       (ex_rs_q),
    .ex_rt       (ex_rt_q),
    .mem_wr      (mem_wr),
    .mem_memrd   (mem_q.ctrl[MEMRD_BIT]),
    .mem_wdst    (mem_q.wdst),
    .wb_wr       (wb_wr),
    .wb_wdst     (wb_q.wdst),
    .stall       (stall),
    .flush_ifid  (bus.flush_ifid),
    .fwd_a       (bus.fwd_a),
    .fwd_b       (bus.fwd_b)
  );

  always_comb begin
    ex_d    = ex_q;
    ex_rs_d = ex_rs_q;
    ex_rt_d = ex_rt_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    if (!bus.hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (stall) begin
        ex_d    = STAGE_BUB;
        ex_rs_d = '0;
        ex_rt_d = '0;
      end else begin
        ex_d    = '{valid: bus.id_valid, ctrl: bus.id_ctrl, wdst: bus.id_wdst};
        ex_rs_d = bus.id_rs;
        ex_rt_d = bus.id_rt;
      end
    end
  end

  // Stage register boundary: ID/EX, EX/MEM, MEM/WB
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q    <= STAGE_RST;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
      mem_q   <= STAGE_RST;
      wb_q    <= STAGE_RST;
    end else begin
      ex_q    <= ex_d;
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.ex_valid  = ex_q.valid;
  assign bus.ex_ctrl   = ex_q.ctrl;
  assign bus.ex_wdst   = ex_q.wdst;
  assign bus.ex_rs     = ex_rs_q;
  assign bus.ex_rt     = ex_rt_q;
  assign bus.mem_valid = mem_q.valid;
  assign bus.mem_ctrl  = mem_q.ctrl;
  assign bus.mem_wdst  = mem_q.wdst;
  assign bus.wb_valid  = wb_q.valid;
  assign bus.wb_ctrl   = wb_q.ctrl;
  assign bus.wb_wdst   = wb_q.wdst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized bench for ctrl_pipe against a behavioural pipeline model.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if bus();

  ctrl_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nchk  = 0;
  int npass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: what each stage holds, as an instruction record.
  typedef struct {
    bit          v;
    logic [14:0] c;
    logic [4:0]  wd;
  } instr_t;

  localparam logic [14:0] RST_CTRL = 15'b000_0000_0001_0000;

  instr_t     m_ex, m_mem, m_wb;
  logic [4:0] m_rs, m_rt;
  bit         e_stall, e_flush;
  logic [1:0] e_fa, e_fb;

  function automatic bit writes(input instr_t s, input logic [4:0] r);
    return s.v && s.c[14] && (s.wd != 5'd0) && (s.wd == r);
  endfunction

  function automatic bit id_depends(input instr_t s);
    return (bus.id_use_rs && writes(s, bus.id_rs)) || (bus.id_use_rt && writes(s, bus.id_rt));
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] r);
`ifdef CTRL_PIPE_FWD_EN
    if (writes(m_mem, r) && !m_mem.c[13]) return 2'b01;
    if (writes(m_wb, r)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  task automatic compute_expected();
    e_stall = 1'b0;
    if (bus.id_valid && !bus.hold) begin
`ifdef CTRL_PIPE_FWD_EN
      e_stall = m_ex.c[13] && id_depends(m_ex);
`else
      e_stall = id_depends(m_ex) || id_depends(m_mem);
`endif
    end
    e_flush = bus.id_redirect && bus.id_valid && !e_stall && !bus.hold;
    e_fa = fwd_of(m_rs);
    e_fb = fwd_of(m_rt);
  endtask

  task automatic compare_all();
    compute_expected();
    check_eq("stall",    bus.stall,      e_stall);
    check_eq("flush",    bus.flush_ifid, e_flush);
    check_eq("fwd_a",    bus.fwd_a,      e_fa);
    check_eq("fwd_b",    bus.fwd_b,      e_fb);
    check_eq("ex_valid", bus.ex_valid,   m_ex.v);
    check_eq("ex_ctrl",  bus.ex_ctrl,    m_ex.c);
    check_eq("ex_wdst",  bus.ex_wdst,    m_ex.wd);
    check_eq("ex_rs",    bus.ex_rs,      m_rs);
    check_eq("ex_rt",    bus.ex_rt,      m_rt);
    check_eq("mem_valid", bus.mem_valid, m_mem.v);
    check_eq("mem_ctrl", bus.mem_ctrl,   m_mem.c);
    check_eq("mem_wdst", bus.mem_wdst,   m_mem.wd);
    check_eq("wb_valid", bus.wb_valid,   m_wb.v);
    check_eq("wb_ctrl",  bus.wb_ctrl,    m_wb.c);
    check_eq("wb_wdst",  bus.wb_wdst,    m_wb.wd);
  endtask

  // Model state change at the rising edge, using inputs held across it.
  task automatic clock_model();
    @(posedge clk);
    if (!rst) begin
      m_ex  = '{v: 1'b0, c: RST_CTRL, wd: 5'd0};
      m_mem = m_ex;
      m_wb  = m_ex;
      m_rs  = 5'd0;
      m_rt  = 5'd0;
    end else if (!bus.hold) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      if (e_stall) begin
        m_ex = '{v: 1'b0, c: 15'd0, wd: 5'd0};
        m_rs = 5'd0;
        m_rt = 5'd0;
      end else begin
        m_ex = '{v: bus.id_valid, c: bus.id_ctrl, wd: bus.id_wdst};
        m_rs = bus.id_rs;
        m_rt = bus.id_rt;
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    bus.hold        = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_ctrl     = 15'd0;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.id_wdst     = 5'd0;
    bus.id_redirect = 1'b0;
  endtask

  task automatic drive_random();
    logic [14:0] c;
    c = 15'($urandom);
    c[14] = ($urandom_range(0, 3) != 0);
    c[13] = ($urandom_range(0, 2) == 0);
    bus.hold        = ($urandom_range(0, 9) == 0);
    bus.id_valid    = ($urandom_range(0, 7) != 0);
    bus.id_ctrl     = c;
    bus.id_rs       = 5'($urandom_range(0, 3));
    bus.id_rt       = 5'($urandom_range(0, 3));
    bus.id_use_rs   = ($urandom_range(0, 4) != 0);
    bus.id_use_rt   = ($urandom_range(0, 2) != 0);
    bus.id_wdst     = 5'($urandom_range(0, 3));
    bus.id_redirect = ($urandom_range(0, 3) == 0);
    rst             = ($urandom_range(0, 49) != 0);
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    m_ex = '{v: 1'b0, c: 15'd0, wd: 5'd0};
    m_mem = m_ex;
    m_wb  = m_ex;
    m_rs  = 5'd0;
    m_rt  = 5'd0;
    e_stall = 1'b0;
    clock_model();
    rst = 1'b1;
    #4;
    compare_all();
    clock_model();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_random();
      #4;
      compare_all();
      clock_model();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
